// File: rtl/dac_dds_mux.sv
`default_nettype none
// ============================================================================
// Module      : dac_dds_mux
// Description : Multi-channel DDS engine with a shared waveform-ROM read port
//               and a shared serial DAC link, serviced in channel order.
//               Each channel owns a phase accumulator and a phase offset; every
//               slot reads one ROM sample and shifts out one addressed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_dds_mux #(
    parameter int         NCH     = 4,
    parameter int         DATA_W  = 12,
    parameter int         ADDR_W  = 9,
    parameter int         ACC_W   = 16,
    parameter int         FRAME_W = 24,
    parameter logic [3:0] CMD     = 4'b0011
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   phase_clr,
    input  logic [NCH*ACC_W-1:0]   freq,
    input  logic [NCH*ACC_W-1:0]   phase_off,
    output logic                   rom_en,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_data,
    output logic                   sync,
    output logic                   din,
    output logic [3:0]             ch_idx,
    output logic                   frame_done
);

    localparam int                 c_bit_w    = $clog2(FRAME_W);
    localparam int                 c_slots    = 16;  // ch is a 4-bit field
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(FRAME_W - 1);
    localparam logic [c_bit_w-1:0] c_done_bit = c_bit_w'(FRAME_W - 2);
    localparam logic [3:0]         c_last_ch  = 4'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CAPT  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t               r_state;
    logic [3:0]           r_ch;
    logic [ACC_W-1:0]     r_acc [c_slots];
    logic [ACC_W-1:0]     r_inc;
    logic [FRAME_W-1:0]   r_shift;
    logic [c_bit_w-1:0]   r_bit;
    logic                 r_sync;
    logic                 r_rom_en;
    logic                 r_frame_done;
    logic [ADDR_W-1:0]    r_rom_addr;

    logic                 w_last;
    logic [3:0]           w_ch_next;
    logic [ACC_W-1:0]     w_acc_next [c_slots];
    logic [ACC_W-1:0]     w_off_next;
    logic [ACC_W-1:0]     w_phase_next;
    logic [ADDR_W-1:0]    w_addr_next;
    logic [FRAME_W-1:0]   w_frame;

    // Last bit of the frame: accumulate, advance channel, leave SHIFT
    assign w_last    = (r_state == S_SHIFT) && (r_bit == c_last_bit);
    assign w_ch_next = w_last ? ((r_ch == c_last_ch) ? 4'd0 : r_ch + 4'd1) : r_ch;

    // Accumulator values after this edge; a clear beats a same-cycle accumulate
    always_comb begin
        for (int k = 0; k < c_slots; k++) begin
            w_acc_next[k] = r_acc[k];
            if (phase_clr) begin
                w_acc_next[k] = '0;
            end else if (w_last && (r_ch == 4'(k))) begin
                w_acc_next[k] = r_acc[k] + r_inc;
            end
        end
    end

    // The ROM address is registered on entry to LOAD, so it is formed from
    // the accumulator and channel values that LOAD itself will see.
    assign w_off_next   = phase_off[w_ch_next*ACC_W +: ACC_W];
    assign w_phase_next = w_acc_next[w_ch_next] + w_off_next;
    assign w_addr_next  = ADDR_W'(w_phase_next >> (ACC_W - ADDR_W));

    // Frame image: command nibble, channel, left-justified sample, zero pad
    always_comb begin
        w_frame                        = '0;
        w_frame[FRAME_W-1 -: 4]        = CMD;
        w_frame[FRAME_W-5 -: 4]        = r_ch;
        w_frame[FRAME_W-9 -: DATA_W]   = rom_data;
    end

    // Slot sequencer: IDLE -> LOAD -> CAPT -> SHIFT x FRAME_W -> LOAD/IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_inc        <= '0;
            r_shift      <= '0;
            r_bit        <= '0;
            r_sync       <= 1'b1;
            r_rom_en     <= 1'b0;
            r_rom_addr   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_rom_en     <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state    <= S_LOAD;
                        r_rom_en   <= 1'b1;
                        r_rom_addr <= w_addr_next;
                    end
                end
                S_LOAD: begin
                    r_inc   <= freq[r_ch*ACC_W +: ACC_W];
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_shift <= w_frame;
                    r_bit   <= '0;
                    r_sync  <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Zeros shift in, so the register is empty once the frame ends
                    r_shift      <= {r_shift[FRAME_W-2:0], 1'b0};
                    r_bit        <= r_bit + c_bit_w'(1);
                    r_frame_done <= (r_bit == c_done_bit);
                    if (w_last) begin
                        r_sync <= 1'b1;
                        r_ch   <= w_ch_next;
                        if (en) begin
                            r_state    <= S_LOAD;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= w_addr_next;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Phase accumulators
    always_ff @(posedge clk) begin
        for (int k = 0; k < c_slots; k++) begin
            if (!rst_n) begin
                r_acc[k] <= '0;
            end else begin
                r_acc[k] <= w_acc_next[k];
            end
        end
    end

    assign rom_en     = r_rom_en;
    assign rom_addr   = r_rom_addr;
    assign sync       = r_sync;
    assign din        = r_shift[FRAME_W-1];
    assign ch_idx     = r_ch;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dac_dds_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_dds_mux
// Description : Self-checking bench for dac_dds_mux (NCH=4 defaults) with a
//               registered ROM model and a phase-accumulator reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_dds_mux;

    localparam int NCH = 4, ACC_W = 16, DATA_W = 12, ADDR_W = 9, FRAME_W = 24;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  phase_clr = 1'b0;
    logic [NCH*ACC_W-1:0]  freq = '0;
    logic [NCH*ACC_W-1:0]  phase_off = '0;
    logic                  rom_en;
    logic [ADDR_W-1:0]     rom_addr;
    logic [DATA_W-1:0]     rom_data = '0;
    logic                  sync;
    logic                  din;
    logic [3:0]            ch_idx;
    logic                  frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dac_dds_mux dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .phase_clr  (phase_clr),
        .freq       (freq),
        .phase_off  (phase_off),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sync       (sync),
        .din        (din),
        .ch_idx     (ch_idx),
        .frame_done (frame_done)
    );

    // ROM contents: distinct, non-trivial sample per address
    function automatic logic [11:0] rom_f(input logic [8:0] a);
        logic [15:0] t;
        t = {7'd0, a} * 16'd37 + 16'd5;
        return t[11:0];
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observe one complete slot starting from its LOAD cycle
    task automatic check_slot(input logic [3:0] ech, input logic [8:0] eaddr, input bit clr_last,
                              output logic [15:0] fused, output time tload);
        int n;
        int sync_bad;
        int fd_bad;
        logic [23:0] bits;
        fused = '0;
        tload = 0;
        n = 0;
        @(negedge clk);
        phase_clr = 1'b0;
        while (rom_en !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("load_seen", rom_en, 1);
        if (rom_en !== 1'b1) return;
        tload = $time;
        chk("load_addr", rom_addr, eaddr);
        chk("load_ch", ch_idx, ech);
        chk("load_sync", sync, 1);
        fused = freq[ech*16 +: 16];
        @(negedge clk);
        chk("capt_romen_sync", {rom_en, sync}, 2'b01);
        bits = '0;
        sync_bad = 0;
        fd_bad = 0;
        for (int i = 0; i < FRAME_W; i++) begin
            @(negedge clk);
            if (clr_last && i == FRAME_W - 1) phase_clr = 1'b1;
            bits = {bits[22:0], din};
            if (sync !== 1'b0) sync_bad++;
            if (frame_done !== (i == FRAME_W - 1)) fd_bad++;
        end
        chk("frame_bits", bits, {4'h3, ech, rom_f(eaddr), 4'h0});
        chk("sync_low_24", sync_bad, 0);
        chk("frame_done_pulse", fd_bad, 0);
    endtask

    task automatic idle_and_clear();
        en = 1'b0;
        repeat (30) @(negedge clk);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
    endtask

    typedef struct {
        logic [3:0][15:0] freq;
        logic [3:0][15:0] off;
        logic [3:0][8:0]  a0;   // addresses in first refresh after clear
        logic [3:0][8:0]  a1;   // addresses in second refresh
    } vec_t;

    vec_t        vt [4];
    logic [15:0] fu;
    time         tl;
    time         tprev;
    int          bad;
    int          low;
    int          fdc;
    int          reload;
    int          n;
    logic [15:0] m_acc [4];
    logic [15:0] sum;
    logic [8:0]  ce [12];

    initial begin
        vt[0].freq = '0;
        vt[0].off  = '0;
        vt[0].a0   = '0;
        vt[0].a1   = '0;
        vt[1].freq = {16'h0200, 16'h0100, 16'h0080, 16'h0000};
        vt[1].off  = '0;
        vt[1].a0   = '0;
        vt[1].a1   = {9'd4, 9'd2, 9'd1, 9'd0};
        vt[2].freq = '0;
        vt[2].off  = {16'h0000, 16'h8000, 16'h0000, 16'h0000};
        vt[2].a0   = {9'd0, 9'd256, 9'd0, 9'd0};
        vt[2].a1   = {9'd0, 9'd256, 9'd0, 9'd0};
        vt[3].freq = {16'h0080, 16'h0001, 16'h0040, 16'hFFFF};
        vt[3].off  = {16'h7F80, 16'hFFFF, 16'h1234, 16'h0080};
        vt[3].a0   = {9'd255, 9'd511, 9'd36, 9'd1};
        vt[3].a1   = {9'd256, 9'd0, 9'd36, 9'd0};
        ce = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd32, 9'd0, 9'd0, 9'd0, 9'd0, 9'd32, 9'd32, 9'd32};

        // Reset, then idle with en low for 100 cycles
        repeat (3) @(negedge clk);
        chk("rst_sync", sync, 1);
        chk("rst_din", din, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ch_idx", ch_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({sync, din, rom_en, frame_done, ch_idx} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) bad++;
        end
        chk("idle_hold_100", bad, 0);

        // Table-driven configurations, two refreshes each
        for (int v = 0; v < 4; v++) begin
            idle_and_clear();
            freq = vt[v].freq;
            phase_off = vt[v].off;
            en = 1'b1;
            for (int s = 0; s < 8; s++) begin
                check_slot(4'(s % 4), (s < 4) ? vt[v].a0[s % 4] : vt[v].a1[s % 4], 1'b0, fu, tl);
                if (s > 0) chk("slot_period", 32'(tl - tprev), 32'd260);
                tprev = tl;
            end
            en = 1'b0;
        end

        // Clear on the last shift cycle of ch0 beats its accumulate
        idle_and_clear();
        freq = {4{16'h1000}};
        phase_off = '0;
        en = 1'b1;
        for (int s = 0; s < 12; s++) begin
            check_slot(4'(s % 4), ce[s], (s == 4), fu, tl);
        end
        en = 1'b0;

        // Randomized rounds against the accumulator reference
        for (int r = 0; r < 3; r++) begin
            idle_and_clear();
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = '0;
                freq[k*16 +: 16] = 16'($urandom);
                phase_off[k*16 +: 16] = 16'($urandom);
            end
            en = 1'b1;
            for (int s = 0; s < 12; s++) begin
                sum = m_acc[s % 4] + phase_off[(s % 4)*16 +: 16];
                check_slot(4'(s % 4), sum[15:7], 1'b0, fu, tl);
                m_acc[s % 4] = m_acc[s % 4] + fu;
                if ($urandom_range(1, 0) == 1) freq[$urandom_range(3, 0)*16 +: 16] = 16'($urandom);
            end
            en = 1'b0;
        end

        // en dropped at shift bit 5: frame completes, channel advances, idle
        idle_and_clear();
        freq = '0;
        en = 1'b1;
        n = 0;
        @(negedge clk);
        while (rom_en !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drop_load_seen", rom_en, 1);
        chk("drop_ch_start", ch_idx, 0);
        @(negedge clk);
        low = 0;
        fdc = 0;
        reload = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 5) en = 1'b0;
            if (sync === 1'b0) low++;
            if (frame_done === 1'b1) fdc++;
            if (rom_en === 1'b1) reload++;
        end
        chk("drop_sync_low", low, 24);
        chk("drop_frame_done", fdc, 1);
        chk("drop_no_reload", reload, 0);
        chk("drop_ch_adv", ch_idx, 1);
        chk("drop_idle_sync", sync, 1);
        en = 1'b1;
        @(negedge clk);
        chk("reassert_load", rom_en, 1);

        // Reset asserted at shift bit 10 of the ch1 frame
        @(negedge clk);
        for (int i = 0; i <= 10; i++) @(negedge clk);
        chk("pre_reset_sync", sync, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sync", sync, 1);
        chk("midrst_din", din, 0);
        chk("midrst_rom_en", rom_en, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_ch_idx", ch_idx, 0);
        chk("midrst_rom_addr", rom_addr, 0);

        // Accumulators restart from zero after reset
        rst_n = 1'b1;
        phase_off = '0;
        freq = {16'h0000, 16'h0000, 16'h0000, 16'h0100};
        en = 1'b1;
        check_slot(4'd0, 9'd0, 1'b0, fu, tl);
        check_slot(4'd1, 9'd0, 1'b0, fu, tl);
        en = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
